// File: rtl/fm_sb_pkg.sv
// Shared types and encodings for the fast-monitoring spy-buffer capture controller.
//   sb_mapped_n    : number of spy buffers under common control
//   pb_mode_width  : width of the playback mode field
//   PB_*           : playback mode encodings (2'b11 is reserved and behaves as capture only)
//   fm_sb_state_t  : sequencer state encoding, as reported on the state output
//   fm_sb_rd_tag_t : per-read tag carried alongside the memory read latency
package fm_sb_pkg;

  localparam int unsigned sb_mapped_n   = 27;
  localparam int unsigned pb_mode_width = 2;

  localparam logic [pb_mode_width-1:0] PB_CAPTURE = 2'b00;
  localparam logic [pb_mode_width-1:0] PB_ONCE    = 2'b01;
  localparam logic [pb_mode_width-1:0] PB_LOOP    = 2'b10;

  typedef enum logic [2:0] {
    FM_SB_IDLE   = 3'd0,
    FM_SB_ARMED  = 3'd1,
    FM_SB_POST   = 3'd2,
    FM_SB_FROZEN = 3'd3,
    FM_SB_PLAY   = 3'd4
  } fm_sb_state_t;

  typedef struct packed {
    logic vld;
    logic last;
  } fm_sb_rd_tag_t;

endpackage

// File: rtl/fm_sb_rd_pipe.sv
// Delay line that aligns {vld,last} read tags with spy-buffer memory read data.
//   spy_clock : clock
//   rst       : asynchronous active-high reset, flushes all stages
//   tag_i     : tag of the read issued this cycle
//   tag_o     : tag delayed by exactly RD_LAT cycles
module fm_sb_rd_pipe
  import fm_sb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic          spy_clock,
  input  logic          rst,
  input  fm_sb_rd_tag_t tag_i,
  output fm_sb_rd_tag_t tag_o
);

  fm_sb_rd_tag_t [RD_LAT-1:0] pipe_q;

  // Shift register; stage 0 captures the incoming tag.
  always_ff @(posedge spy_clock or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/fm_sb_capture_ctrl.sv
// Capture / freeze / playback sequencer shared by all fast-monitoring spy buffers.
//   spy_clock, rst        : clock and asynchronous active-high reset
//   sb_enable             : per-buffer capture enable mask
//   pb_mode               : playback mode (capture only / once / loop)
//   arm, sw_freeze,
//   ext_trig, pb_start    : single-cycle control pulses
//   post_trig_cnt         : writes performed after the trigger write
//   pb_len                : entries per playback pass, 0 means full depth
//   sb_we, wr_addr        : lockstep write enables (combinational) and common write pointer
//   rd_en, rd_addr        : common playback read port
//   pb_vld, pb_last       : read data valid / last-of-pass, aligned to memory latency
//   trig_addr, wrapped,
//   frozen, state         : status
module fm_sb_capture_ctrl
  import fm_sb_pkg::*;
#(
  parameter int unsigned SB_N   = sb_mapped_n,
  parameter int unsigned AW     = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                     spy_clock,
  input  logic                     rst,
  input  logic [SB_N-1:0]          sb_enable,
  input  logic [pb_mode_width-1:0] pb_mode,
  input  logic                     arm,
  input  logic                     sw_freeze,
  input  logic                     ext_trig,
  input  logic [AW-1:0]            post_trig_cnt,
  input  logic [AW-1:0]            pb_len,
  input  logic                     pb_start,
  output logic [SB_N-1:0]          sb_we,
  output logic [AW-1:0]            wr_addr,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_addr,
  output logic                     pb_vld,
  output logic                     pb_last,
  output logic [AW-1:0]            trig_addr,
  output logic                     wrapped,
  output logic                     frozen,
  output logic [2:0]               state
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_PASS = CW'(1) << AW;

  localparam logic [2:0] ST_IDLE   = FM_SB_IDLE;
  localparam logic [2:0] ST_ARMED  = FM_SB_ARMED;
  localparam logic [2:0] ST_POST   = FM_SB_POST;
  localparam logic [2:0] ST_FROZEN = FM_SB_FROZEN;
  localparam logic [2:0] ST_PLAY   = FM_SB_PLAY;

  logic [2:0]               state_q,     state_d;
  logic                     capturing_q, capturing_d;
  logic [AW-1:0]            wr_addr_q,   wr_addr_d;
  logic                     wrapped_q,   wrapped_d;
  logic [AW-1:0]            trig_addr_q, trig_addr_d;
  logic [AW-1:0]            post_cnt_q,  post_cnt_d;
  logic                     rd_en_q,     rd_en_d;
  logic [AW-1:0]            rd_addr_q,   rd_addr_d;
  logic [AW-1:0]            start_q,     start_d;
  logic [CW-1:0]            pass_cnt_q,  pass_cnt_d;
  logic [pb_mode_width-1:0] pb_mode_q,   pb_mode_d;
  logic [AW-1:0]            pb_len_q,    pb_len_d;
  logic                     frozen_q,    frozen_d;

  logic          write_c;
  logic          trig_c;
  logic          play_ok_c;
  fm_sb_rd_tag_t tag_in_c;
  fm_sb_rd_tag_t tag_out_c;

  // Pass length with 0 standing for the full ring depth.
  function automatic logic [CW-1:0] pass_len_f(input logic [AW-1:0] len);
    return (len == '0) ? FULL_PASS : {1'b0, len};
  endfunction

  // A software freeze in POST suppresses that cycle's write.
  assign write_c   = capturing_q & ~((state_q == ST_POST) & sw_freeze);
  assign trig_c    = ext_trig | sw_freeze;
  assign play_ok_c = (pb_mode == PB_ONCE) || (pb_mode == PB_LOOP);

  assign sb_we = sb_enable & {SB_N{write_c}};

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    capturing_d = capturing_q;
    wr_addr_d   = wr_addr_q;
    wrapped_d   = wrapped_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    start_d     = start_q;
    pass_cnt_d  = pass_cnt_q;
    pb_mode_d   = pb_mode_q;
    pb_len_d    = pb_len_q;

    // Pointer advances on every capturing cycle regardless of the enable mask.
    if (write_c) begin
      wr_addr_d = wr_addr_q + AW'(1);
      if (wr_addr_q == '1) begin
        wrapped_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          capturing_d = 1'b1;
          wr_addr_d   = '0;
          wrapped_d   = 1'b0;
        end
      end

      ST_ARMED: begin
        if (trig_c) begin
          trig_addr_d = wr_addr_q;
          if (post_trig_cnt == '0) begin
            state_d     = ST_FROZEN;
            capturing_d = 1'b0;
          end else begin
            state_d    = ST_POST;
            post_cnt_d = post_trig_cnt;
          end
        end
      end

      ST_POST: begin
        if (sw_freeze) begin
          state_d     = ST_FROZEN;
          capturing_d = 1'b0;
        end else begin
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) begin
            state_d     = ST_FROZEN;
            capturing_d = 1'b0;
          end
        end
      end

      ST_FROZEN: begin
        if (arm) begin
          state_d     = ST_ARMED;
          capturing_d = 1'b1;
          wr_addr_d   = '0;
          wrapped_d   = 1'b0;
        end else if (pb_start && play_ok_c) begin
          // Oldest entry sits at the write pointer once the ring has wrapped.
          state_d    = ST_PLAY;
          rd_en_d    = 1'b1;
          start_d    = wrapped_q ? wr_addr_q : '0;
          rd_addr_d  = wrapped_q ? wr_addr_q : '0;
          pb_mode_d  = pb_mode;
          pb_len_d   = pb_len;
          pass_cnt_d = pass_len_f(pb_len);
        end
      end

      ST_PLAY: begin
        if (sw_freeze) begin
          state_d = ST_FROZEN;
          rd_en_d = 1'b0;
        end else if (pass_cnt_q == CW'(1)) begin
          if (pb_mode_q == PB_LOOP) begin
            rd_addr_d  = start_q;
            pass_cnt_d = pass_len_f(pb_len_q);
          end else begin
            state_d = ST_FROZEN;
            rd_en_d = 1'b0;
          end
        end else begin
          rd_addr_d  = rd_addr_q + AW'(1);
          pass_cnt_d = pass_cnt_q - CW'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        capturing_d = 1'b0;
        rd_en_d     = 1'b0;
      end
    endcase

    frozen_d = (state_d == ST_FROZEN);
  end

  // State and datapath registers.
  always_ff @(posedge spy_clock or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      capturing_q <= 1'b0;
      wr_addr_q   <= '0;
      wrapped_q   <= 1'b0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      start_q     <= '0;
      pass_cnt_q  <= '0;
      pb_mode_q   <= PB_CAPTURE;
      pb_len_q    <= '0;
      frozen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      capturing_q <= capturing_d;
      wr_addr_q   <= wr_addr_d;
      wrapped_q   <= wrapped_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      start_q     <= start_d;
      pass_cnt_q  <= pass_cnt_d;
      pb_mode_q   <= pb_mode_d;
      pb_len_q    <= pb_len_d;
      frozen_q    <= frozen_d;
    end
  end

  // Last tag marks the final read of a complete pass.
  assign tag_in_c.vld  = rd_en_q;
  assign tag_in_c.last = rd_en_q & (pass_cnt_q == CW'(1));

  fm_sb_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .spy_clock (spy_clock),
    .rst       (rst),
    .tag_i     (tag_in_c),
    .tag_o     (tag_out_c)
  );

  assign wr_addr   = wr_addr_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign pb_vld    = tag_out_c.vld;
  assign pb_last   = tag_out_c.last;
  assign trig_addr = trig_addr_q;
  assign wrapped   = wrapped_q;
  assign frozen    = frozen_q;
  assign state     = state_q;

endmodule

// File: doc/fm_sb_capture_ctrl.md
Name: fm_sb_capture_ctrl

Overview:
Global capture/freeze/playback sequencer shared by the fast-monitoring spy buffers (SB0..SB26).
- Drives one common ring write pointer and per-buffer write enables, so all buffers capture in lockstep.
- Freezes all buffers a programmable number of cycles after a trigger.
- Sequences read-out playback from the frozen buffers according to pb_mode.
- Sits between FM_CTRL register fields and the spy-buffer memory array in the spy_clock domain.

Parameters:
- SB_N, 27, number of spy buffers controlled (sb_mapped_n).
- AW, 10, spy-buffer address width; depth = 2^AW.
- RD_LAT, 2, spy-buffer memory read latency in cycles (1..4).

Ports:
- spy_clock  in  1  capture/playback clock.
- rst  in  1  asynchronous, active-high reset.
- sb_enable  in  SB_N  per-buffer capture enable mask.
- pb_mode  in  2  00 capture only, 01 playback once, 10 playback loop, 11 reserved (treated as 00).
- arm  in  1  pulse: start capturing.
- sw_freeze  in  1  pulse: software trigger/abort/stop.
- ext_trig  in  1  pulse: external trigger.
- post_trig_cnt  in  AW  writes performed after the trigger cycle.
- pb_len  in  AW  entries per playback pass; 0 means 2^AW.
- pb_start  in  1  pulse: begin playback.
- sb_we  out  SB_N  per-buffer write enable.
- wr_addr  out  AW  common write address.
- rd_en  out  1  memory read enable.
- rd_addr  out  AW  common read address.
- pb_vld  out  1  read data valid (rd_en delayed by RD_LAT).
- pb_last  out  1  last entry of a pass, aligned with pb_vld.
- trig_addr  out  AW  wr_addr captured on the trigger cycle.
- wrapped  out  1  ring has wrapped since arm.
- frozen  out  1  state is FROZEN.
- state  out  3  IDLE=0, ARMED=1, POST=2, FROZEN=3, PLAY=4.

Behaviour:
- Reset (async, any time, including mid-capture or mid-playback):
  - state=IDLE; every output 0.
  - Read-latency pipeline flushed, so no pb_vld/pb_last emerges after reset release.
- sb_we = sb_enable AND capturing, where capturing is a registered flag, true in ARMED/POST.
  - A change to sb_enable takes effect in the same cycle.
  - wr_addr increments by 1 mod 2^AW every capturing cycle, whether or not any enable bit is set.
  - wrapped sets when a write occurs at wr_addr = 2^AW-1.
- IDLE: no writes. arm -> ARMED, wr_addr=0, wrapped=0; first write happens in the next cycle.
- ARMED, on ext_trig or sw_freeze (simultaneous pulses count as one trigger):
  - trig_addr = wr_addr of this cycle's write (that write still occurs).
  - post_trig_cnt=0 -> FROZEN; else POST with down-counter = post_trig_cnt.
- POST:
  - Writes continue; counter decrements per write; the write with counter=1 is the last, then -> FROZEN.
  - Exactly post_trig_cnt writes follow the trigger write.
  - sw_freeze -> FROZEN immediately, with no write that cycle.
  - ext_trig is ignored.
- FROZEN: sb_we=0, frozen=1, wr_addr held.
  - arm -> ARMED (re-arm, pointer and wrapped cleared); arm wins over a simultaneous pb_start.
  - pb_start with pb_mode 01/10 -> PLAY; pb_start with pb_mode 00/11 is ignored.
  - PLAY start address S = wr_addr (oldest entry) if wrapped, else 0.
  - pb_mode and pb_len are latched at pb_start.
- PLAY: rd_en=1 every cycle, rd_addr starts at S and increments mod 2^AW.
  - The pass length counter is loaded with the latched pb_len (0 -> 2^AW).
  - On the last read of a pass, pb_last is tagged into the pipeline.
  - Mode 01: -> FROZEN after the last read.
  - Mode 10: rd_addr reloads S and the counter reloads with no idle cycle.
  - sw_freeze: current read completes, then -> FROZEN; no pb_last is emitted for a truncated pass.
  - arm and ext_trig are ignored.
- pb_vld/pb_last: rd_en/last-tag delayed exactly RD_LAT cycles. The pipeline drains naturally after leaving PLAY.
- Ignored inputs: arm in ARMED/POST/PLAY; ext_trig outside ARMED; pb_start outside FROZEN.
- All outputs except sb_we are registered.

Decomposition:
- fm_sb_pkg gains:
  - state enum type fm_sb_state_t.
  - pb_mode encodings PB_CAPTURE=2'b00, PB_ONCE=2'b01, PB_LOOP=2'b10.
  - Reuses pb_mode_width and sb_mapped_n.
- One sub-module: fm_sb_rd_pipe, a RD_LAT-deep shift register carrying {vld,last} with async reset.

Test Plan:
- AW=4, arm, ext_trig on 6th write (wr_addr=5), post_trig_cnt=3 -> trig_addr=5; writes at 5,6,7,8; state FROZEN; wr_addr=9; wrapped=0.
- arm, no trigger for 20 cycles (wrap at 16), sw_freeze at wr_addr=3, post_trig_cnt=0 -> wrapped=1, FROZEN; playback-once pb_len=0 reads 4..15,0..3; pb_vld for 16 cycles starting RD_LAT after the first rd_en; pb_last on the 16th.
- FROZEN, pb_mode=10, pb_len=3, start 0 -> rd_addr 0,1,2,0,1,2…; sw_freeze mid-pass -> FROZEN after the current read; no pb_last for the truncated pass.
- sb_enable=27'h0000005 during capture -> only sb_we[0] and sb_we[2] toggle; toggling bit 1 mid-capture affects sb_we[1] in the same cycle.
- In POST with counter=5, assert rst -> all outputs 0 immediately; after release, no pb_vld and state=IDLE; pb_start ignored.
- In FROZEN, arm and pb_start in the same cycle -> ARMED, wr_addr=0, rd_en stays 0; pb_mode=11 with pb_start -> stays FROZEN.
